// File: rtl/fm_pkg.sv
// Shared types, flash layout constants and base-address helper for the
// neuron-parameter fetch sequencer.
package fm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } fm_state_t;

    localparam logic [15:0] HID_REC_LEN    = 16'd37;
    localparam logic [15:0] OUT_REC_LEN    = 16'd3;
    localparam logic [15:0] OUT_BASE       = 16'd296;
    localparam logic [15:0] FM_TOTAL_WORDS = 16'd326;

    // Hidden records pack from address 0; output records follow them.
    function automatic logic [15:0] fm_base_addr(input logic layer, input logic [3:0] neuron);
        logic [15:0] n16;
        n16 = {12'd0, neuron};
        if (layer) begin
            fm_base_addr = OUT_BASE + n16 * OUT_REC_LEN;
        end else begin
            fm_base_addr = n16 * HID_REC_LEN;
        end
    endfunction

endpackage

// File: rtl/fm_fetch_wait_timer.sv
// fm_wait_timer: loadable down-counter with zero flag that paces flash reads.
module fm_wait_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; otherwise count down to zero and stick there.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fm_fetch_ctrl.sv
// Neuron-record fetch sequencer: drives the flash address, waits READ_WAIT
// cycles per word and streams words on valid/ready. Option: FM_FETCH_CHECKSUM_EN.
module fm_fetch_ctrl
    import fm_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned READ_WAIT   = 2,
    parameter int unsigned HID_NEURONS = 8,
    parameter int unsigned HID_WORDS   = 36,
    parameter int unsigned OUT_NEURONS = 10,
    parameter int unsigned OUT_WORDS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              layer,
    input  logic [3:0]        neuron,
    output logic [ADDR_W-1:0] fm_addr,
    input  logic [15:0]       fm_data,
    output logic              busy,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [15:0]       word_data,
    output logic              word_is_bias,
    output logic [5:0]        word_idx,
    output logic              word_last,
    output logic              done,
    output logic              err,
    output logic [15:0]       checksum
);

    fm_state_t         state_q, state_d;
    logic [ADDR_W-1:0] fm_addr_q, fm_addr_d;
    logic [5:0]        word_idx_q, word_idx_d;
    logic [15:0]       word_data_q, word_data_d;
    logic              layer_q, layer_d;
    logic              err_q, err_d;
    logic              tmr_load_s;
    logic              tmr_zero_s;
    logic              neuron_ok_s;
    logic              accept_s;
    logic              handshake_s;
    logic [5:0]        last_idx_s;

    fm_wait_timer #(.W(4)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (4'(READ_WAIT)),
        .en       (state_q == S_WAIT),
        .zero     (tmr_zero_s)
    );

    assign neuron_ok_s = layer ? ({28'd0, neuron} < OUT_NEURONS)
                               : ({28'd0, neuron} < HID_NEURONS);
    assign accept_s    = (state_q == S_IDLE) && start && neuron_ok_s;
    assign last_idx_s  = layer_q ? 6'(OUT_WORDS) : 6'(HID_WORDS);
    assign handshake_s = word_valid && word_ready;

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        fm_addr_d   = fm_addr_q;
        word_idx_d  = word_idx_q;
        word_data_d = word_data_q;
        layer_d     = layer_q;
        err_d       = 1'b0;
        tmr_load_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && neuron_ok_s) begin
                    layer_d    = layer;
                    fm_addr_d  = ADDR_W'(fm_base_addr(layer, neuron));
                    word_idx_d = 6'd0;
                    tmr_load_s = 1'b1;
                    state_d    = S_WAIT;
                end else if (start) begin
                    err_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (tmr_zero_s) begin
                    word_data_d = fm_data;
                    state_d     = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (handshake_s && word_last) begin
                    state_d = S_DONE;
                end else if (handshake_s) begin
                    fm_addr_d  = fm_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    word_idx_d = word_idx_q + 6'd1;
                    tmr_load_s = 1'b1;
                    state_d    = S_WAIT;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fm_addr_q   <= '0;
            word_idx_q  <= 6'd0;
            word_data_q <= 16'd0;
            layer_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fm_addr_q   <= fm_addr_d;
            word_idx_q  <= word_idx_d;
            word_data_q <= word_data_d;
            layer_q     <= layer_d;
            err_q       <= err_d;
        end
    end

`ifdef FM_FETCH_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    // Running sum restarts with each accepted request.
    always_comb begin
        checksum_d = checksum_q;
        if (accept_s) begin
            checksum_d = 16'd0;
        end else if (handshake_s) begin
            checksum_d = checksum_q + word_data_q;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= 16'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'd0;
`endif

    assign fm_addr      = fm_addr_q;
    assign word_idx     = word_idx_q;
    assign word_data    = word_data_q;
    assign busy         = (state_q != S_IDLE);
    assign word_valid   = (state_q == S_HOLD);
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    // Tags are qualified by valid so they read 0 outside a presented word.
    assign word_is_bias = word_valid && (word_idx_q == 6'd0);
    assign word_last    = word_valid && (word_idx_q == last_idx_s);

endmodule

// File: tb/tb_fm_fetch_ctrl.sv
// Scoreboard bench for fm_fetch_ctrl: stimulus pushes expected words, a
// negedge monitor pops and compares on every handshake.
module tb_fm_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, layer, word_ready;
    logic [3:0]  neuron;
    logic [15:0] fm_addr, fm_data, word_data, checksum;
    logic        busy, word_valid, word_is_bias, word_last, done, err;
    logic [5:0]  word_idx;

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  idx;
        logic        bias;
        logic        last;
        logic [15:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_rise = -1;
    bit          spacing_en = 1'b0;
    logic        prev_valid = 1'b0;
    logic [15:0] exp_sum = 16'd0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mw(input logic [15:0] a);
        return (a * 16'd257) ^ 16'h5A5A;
    endfunction

    assign fm_data = mw(fm_addr);

    fm_fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .layer(layer), .neuron(neuron),
        .fm_addr(fm_addr), .fm_data(fm_data), .busy(busy), .word_valid(word_valid),
        .word_ready(word_ready), .word_data(word_data), .word_is_bias(word_is_bias),
        .word_idx(word_idx), .word_last(word_last), .done(done), .err(err),
        .checksum(checksum)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_ck();
`ifdef FM_FETCH_CHECKSUM_EN
        return exp_sum;
`else
        return 16'd0;
`endif
    endfunction

    // Monitor: scoreboard pop on handshake, done counting, valid spacing.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done) done_cnt++;
        if (!rst && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {26'd0, word_idx}, 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("word_data", word_data, e.data);
                chk("word_idx", word_idx, e.idx);
                chk("word_is_bias", word_is_bias, e.bias);
                chk("word_last", word_last, e.last);
                chk("fm_addr", fm_addr, e.addr);
            end
        end
        if (word_valid && !prev_valid) begin
            if (spacing_en && last_rise >= 0) chk("valid_spacing", cyc - last_rise, 4);
            last_rise = cyc;
        end
        prev_valid = word_valid;
    end

    task automatic push_rec(input logic l, input int n);
        int len, base;
        len     = l ? 3 : 37;
        base    = l ? (296 + n * 3) : (n * 37);
        exp_sum = 16'd0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({mw(16'(base + i)), 6'(i), (i == 0), (i == len - 1), 16'(base + i)});
            exp_sum = exp_sum + mw(16'(base + i));
        end
    endtask

    task automatic do_start(input logic l, input logic [3:0] n);
        @(posedge clk); #1;
        start = 1'b1; layer = l; neuron = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_checksum"}, checksum, exp_ck());
        @(negedge clk);
        chk({name, "_done_one_cycle"}, done, 0);
        chk({name, "_idle_after"}, busy, 0);
        chk({name, "_done_count"}, done_cnt, 1);
        chk({name, "_checksum_stable"}, checksum, exp_ck());
        done_cnt = 0;
    endtask

    task automatic wait_idx(input logic [5:0] idx, input bit want_valid);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (word_idx == idx && word_valid == want_valid) begin seen = 1'b1; break; end
        end
        chk("wait_idx_timeout", seen, 1);
    endtask

    initial begin
        logic [15:0] h_data;
        logic [5:0]  h_idx;
        int          lat;
        rst = 1'b1; start = 1'b0; layer = 1'b0; neuron = 4'd0; word_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fm_addr", fm_addr, 0);
        chk("rst_word_data", word_data, 0);
        chk("rst_word_idx", word_idx, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_outs", {busy, word_valid, word_is_bias, word_last, done, err}, 0);
        @(negedge clk); rst = 1'b0;

        // Hidden neuron 0, ready high: latency, spacing, full record.
        push_rec(1'b0, 0);
        spacing_en = 1'b1; last_rise = -1;
        do_start(1'b0, 4'd0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (word_valid) begin lat = k; break; end
        end
        chk("first_latency", lat, 3);
        wait_done("hid0");
        spacing_en = 1'b0;
        chk("hid0_last_addr", fm_addr, 36);

        // Output neuron 9: addresses 323..325.
        push_rec(1'b1, 9);
        do_start(1'b1, 4'd9);
        wait_done("out9");
        chk("out9_last_addr", fm_addr, 325);

        // Invalid requests.
        do_start(1'b0, 4'd8);
        chk("inv_hid_err", err, 1);
        chk("inv_hid_busy", busy, 0);
        chk("inv_hid_addr", fm_addr, 325);
        @(posedge clk); #1;
        chk("inv_hid_err_pulse", err, 0);
        chk("inv_hid_busy2", busy, 0);
        do_start(1'b1, 4'd10);
        chk("inv_out_err", err, 1);
        chk("inv_out_busy", busy, 0);
        chk("inv_out_addr", fm_addr, 325);
        chk("inv_checksum_kept", checksum, exp_ck());
        @(posedge clk); #1;
        chk("inv_out_err_pulse", err, 0);

        // Backpressure on idx 3 of hidden neuron 2.
        push_rec(1'b0, 2);
        do_start(1'b0, 4'd2);
        wait_idx(6'd3, 1'b0);
        word_ready = 1'b0;
        wait_idx(6'd3, 1'b1);
        h_data = word_data; h_idx = word_idx;
        chk("bp_held_data", h_data, mw(16'd77));
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", word_valid, 1);
            chk("bp_data_hold", word_data, mw(16'd77));
            chk("bp_idx_hold", word_idx, 3);
            chk("bp_addr_hold", fm_addr, 77);
        end
        word_ready = 1'b1;
        wait_done("bp");

        // Start while busy is ignored.
        push_rec(1'b0, 3);
        do_start(1'b0, 4'd3);
        wait_idx(6'd5, 1'b1);
        start = 1'b1; layer = 1'b1; neuron = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start_no_err", err, 0);
        wait_done("busy_start");
        chk("busy_start_last_addr", fm_addr, 147);

        // Reset during WAIT at idx 10, then hidden neuron 1.
        push_rec(1'b0, 4);
        do_start(1'b0, 4'd4);
        wait_idx(6'd10, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_fm_addr", fm_addr, 0);
        chk("mid_rst_word_data", word_data, 0);
        chk("mid_rst_word_idx", word_idx, 0);
        chk("mid_rst_checksum", checksum, 0);
        chk("mid_rst_outs", {busy, word_valid, word_is_bias, word_last, done, err}, 0);
        exp_q.delete();
        exp_sum = 16'd0;
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_done", done_cnt, 0);
        push_rec(1'b0, 1);
        do_start(1'b0, 4'd1);
        #1;
        chk("after_rst_base", fm_addr, 37);
        wait_done("hid1");
        chk("hid1_last_addr", fm_addr, 73);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fm_fetch_ctrl.md
# fm_fetch_ctrl

Sequencer that reads one neuron's parameter record from the external flash memory and streams it to the neural-net datapath. It sits between the layer engine (hidden and output MAC units) and the flash model. It owns the flash address bus, and it inserts the programmable read-wait delay. It presents each fetched word on a valid/ready handshake, tagged with its position in the record.

## Interface
- ADDR_W, 16, flash address width
- READ_WAIT, 2, extra cycles between driving fm_addr and sampling fm_data (0..15)
- HID_NEURONS, 8, hidden neuron count
- HID_WORDS, 36, weight words per hidden neuron
- OUT_NEURONS, 10, output neuron count
- OUT_WORDS, 2, weight words per output neuron
- Clock and reset: single clock `clk`; reset `rst` is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request pulse; sampled only in IDLE
- layer  in  1  0 = hidden, 1 = output
- neuron  in  4  neuron index within layer
- fm_addr  out  ADDR_W  flash address (registered)
- fm_data  in  16  flash read data
- busy  out  1  high whenever state is not IDLE
- word_valid  out  1  word_data holds a fetched word
- word_ready  in  1  consumer accepts the word
- word_data  out  16  fetched word (registered)
- word_is_bias  out  1  word is the record's bias (offset 0)
- word_idx  out  6  offset within record, 0 = bias
- word_last  out  1  final word of record
- done  out  1  one-cycle pulse after last handshake
- err  out  1  one-cycle pulse on out-of-range neuron
- checksum  out  16  running sum of delivered words (see Configuration)

## Operation
- Flash layout, in words:
  - Hidden neuron n: base n*37; bias first, then 36 weights.
  - Output neuron n: base 296 + n*3; bias first, then 2 weights.
  - Total 326 words.
- Record length: 37 for hidden, 3 for output.
- States: IDLE, WAIT, HOLD, DONE.
- IDLE, start=1, index valid: latch layer and neuron, fm_addr <= base, word_idx <= 0, wait counter <= READ_WAIT, go to WAIT.
- IDLE, start=1, neuron >= layer count (hidden >= 8, output >= 10): err=1 for one cycle, stay IDLE, fm_addr unchanged.
- WAIT: if the counter is nonzero, decrement it. If it is zero, capture word_data <= fm_data, set word_valid, go to HOLD.
- HOLD:
  - word_data, word_idx, word_is_bias and word_last are stable until the handshake.
  - On word_valid & word_ready with word_last=0: clear valid, fm_addr+1, word_idx+1, reload counter, go to WAIT.
  - On the handshake with word_last=1: go to DONE.
- DONE: done=1 for one cycle, then IDLE; fm_addr holds the last address.
- start outside IDLE is ignored (no queuing); layer and neuron are don't-care outside IDLE.
- word_last = (word_idx == record length − 1). word_is_bias = (word_idx == 0).
- Address arithmetic uses ADDR_W bits unsigned; no wrap occurs within the 326-word layout.

## Timing
- Reset values: fm_addr=0, word_data=0, word_idx=0, checksum=0, state IDLE. All other outputs (busy, word_valid, word_is_bias, word_last, done, err) are 0.
- Reset mid-fetch returns immediately to IDLE with reset values; no partial done.
- Latency from start sampled to word_valid high is READ_WAIT+1 cycles.
- After each handshake edge, the next word_valid arrives READ_WAIT+1 cycles later.
- With word_ready held high, peak rate is one word per READ_WAIT+2 cycles.
- The done pulse is in the cycle after the last handshake; a new start is accepted the cycle after done.
- err pulses in the cycle after the offending start.

## Configuration
- FM_FETCH_CHECKSUM_EN defined:
  - checksum adds word_data (mod 2^16) on every handshake.
  - It clears when a valid start is accepted.
  - It is valid and stable while done is high and until the next accepted start.
- FM_FETCH_CHECKSUM_EN undefined: checksum is tied to 0 and no adder is built.

## Structure
- Package fm_pkg holds:
  - the state enum fm_state_t;
  - the constants HID_REC_LEN=37, OUT_REC_LEN=3, OUT_BASE=296, FM_TOTAL_WORDS=326;
  - a function computing base address from layer and neuron.
- Sub-module fm_wait_timer is a loadable down-counter with a zero flag, driven by READ_WAIT.
- The top level holds the FSM, address/index registers, output register and checksum.

## Test plan
- Hidden neuron 0, READ_WAIT=2, ready tied high:
  - fm_addr steps 0..36; 37 words are delivered.
  - word_is_bias is set only on idx 0; word_last is set only on idx 36.
  - done pulses once; valid spacing is 4 cycles.
- Output neuron 9: fm_addr sequence is 323, 324, 325. word_last is set on idx 2. checksum equals the sum of the three model words.
- Backpressure: drop word_ready for 5 cycles on idx 3. word_data and word_idx hold, fm_addr does not advance, and no word is lost or duplicated.
- Invalid requests:
  - start with layer=0, neuron=8: err pulses and busy stays 0.
  - start with layer=1, neuron=10: same response.
- Start while busy: a second start at idx 5 is ignored and the original record completes unchanged.
- Reset asserted during WAIT at idx 10: outputs go to reset values immediately. A new start for hidden neuron 1 afterwards fetches from address 37.
